// File: rtl/csr_ctrl.sv
// csr_ctrl: multi-cycle CSR read-modify-write and ecall/mret trap sequencer.
// One instruction flows through IDLE -> READ -> WRITE -> RESP; the result is
// held in RESP until the downstream handshake completes.
module csr_ctrl #(
    parameter int XLEN        = 32,
    parameter int ECALL_CAUSE = 11
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic            is_ecall_i,
    input  logic            is_mret_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [4:0]      zimm_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [11:0]     csr_addr_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            csr_we_o,
    output logic            is_ecall_o,
    output logic            is_mret_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [4:0]      rd_o,
    output logic            rd_we_o,
    output logic [XLEN-1:0] rd_wdata_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            illegal_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              ecall_q, ecall_d;
    logic              mret_q, mret_d;
    logic [11:0]       addr_q, addr_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [4:0]        zimm_q, zimm_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   old_q, old_d;

    logic              accept;
    logic              is_csr;
    logic              illegal;
    logic              wr_en;
    logic [XLEN-1:0]   src;
    logic [XLEN-1:0]   new_val;
    logic [11:0]       access_addr;

    assign accept = (state_q == IDLE) && in_valid_i && rst_i;

    // Decode of the latched instruction; mret_q is already masked by ecall.
    always_comb begin
        is_csr      = ~ecall_q & ~mret_q;
        illegal     = is_csr & (op_q[1:0] == 2'b00);
        src         = op_q[2] ? {{(XLEN-5){1'b0}}, zimm_q} : rs1_q;
        new_val     = src;
        case (op_q[1:0])
            2'b10:   new_val = old_q | src;
            2'b11:   new_val = old_q & ~src;
            default: new_val = src;
        endcase
        // Set/clear with x0 or a zero immediate must not touch the CSR.
        wr_en       = is_csr & ~illegal & ~((op_q[1:0] != 2'b01) && (zimm_q == 5'd0));
        access_addr = ecall_q ? 12'h305 : (mret_q ? 12'h341 : addr_q);
    end

    // Next-state logic for the sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Instruction capture on accept and old-value capture in READ.
    always_comb begin
        op_d    = op_q;
        ecall_d = ecall_q;
        mret_d  = mret_q;
        addr_d  = addr_q;
        rs1_d   = rs1_q;
        zimm_d  = zimm_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        old_d   = old_q;
        if (accept) begin
            op_d    = op_i;
            ecall_d = is_ecall_i;
            mret_d  = is_mret_i & ~is_ecall_i;
            addr_d  = csr_addr_i;
            rs1_d   = rs1_data_i;
            zimm_d  = zimm_i;
            rd_d    = rd_i;
            pc_d    = pc_i;
        end
        if (state_q == READ) old_d = csr_rdata_i;
    end

    // State register with asynchronous reset; drops any in-flight instruction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers; only meaningful while the FSM is out of IDLE.
    always_ff @(posedge clk_i) begin
        op_q    <= op_d;
        ecall_q <= ecall_d;
        mret_q  <= mret_d;
        addr_q  <= addr_d;
        rs1_q   <= rs1_d;
        zimm_q  <= zimm_d;
        rd_q    <= rd_d;
        pc_q    <= pc_d;
        old_q   <= old_d;
    end

    // Per-state output decode; everything not driven by a state stays 0.
    always_comb begin
        in_ready_o    = 1'b0;
        csr_addr_o    = '0;
        csr_wdata_o   = '0;
        csr_we_o      = 1'b0;
        is_ecall_o    = 1'b0;
        is_mret_o     = 1'b0;
        mepc_o        = '0;
        mcause_o      = '0;
        out_valid_o   = 1'b0;
        rd_o          = '0;
        rd_we_o       = 1'b0;
        rd_wdata_o    = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        illegal_o     = 1'b0;
        case (state_q)
            IDLE: in_ready_o = rst_i;
            READ: csr_addr_o = access_addr;
            WRITE: begin
                csr_addr_o  = access_addr;
                csr_we_o    = wr_en;
                csr_wdata_o = wr_en ? new_val : '0;
                is_ecall_o  = ecall_q;
                is_mret_o   = mret_q;
                if (ecall_q) begin
                    mepc_o   = pc_q;
                    mcause_o = XLEN'(ECALL_CAUSE);
                end
            end
            RESP: begin
                out_valid_o = 1'b1;
                illegal_o   = illegal;
                if (is_csr) begin
                    rd_o       = rd_q;
                    rd_wdata_o = old_q;
                    rd_we_o    = (rd_q != 5'd0) & ~illegal;
                end else begin
                    redirect_o    = 1'b1;
                    redirect_pc_o = ecall_q ? {old_q[XLEN-1:2], 2'b00} : old_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: directed and randomized transactions checked cycle by cycle
// against a behavioural model of the CSR/trap sequencer.
module tb_csr_ctrl;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [2:0]      op_i = '0;
    logic            is_ecall_i = 1'b0;
    logic            is_mret_i = 1'b0;
    logic [11:0]     csr_addr_i = '0;
    logic [XLEN-1:0] rs1_data_i = '0;
    logic [4:0]      zimm_i = '0;
    logic [4:0]      rd_i = '0;
    logic [XLEN-1:0] pc_i = '0;
    logic [11:0]     csr_addr_o;
    logic [XLEN-1:0] csr_rdata_i = '0;
    logic [XLEN-1:0] csr_wdata_o;
    logic            csr_we_o;
    logic            is_ecall_o;
    logic            is_mret_o;
    logic [XLEN-1:0] mepc_o;
    logic [XLEN-1:0] mcause_o;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [4:0]      rd_o;
    logic            rd_we_o;
    logic [XLEN-1:0] rd_wdata_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            illegal_o;

    int total = 0;
    int bad   = 0;

    csr_ctrl #(.XLEN(XLEN), .ECALL_CAUSE(11)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_i(op_i), .is_ecall_i(is_ecall_i), .is_mret_i(is_mret_i),
        .csr_addr_i(csr_addr_i), .rs1_data_i(rs1_data_i), .zimm_i(zimm_i),
        .rd_i(rd_i), .pc_i(pc_i),
        .csr_addr_o(csr_addr_o), .csr_rdata_i(csr_rdata_i),
        .csr_wdata_o(csr_wdata_o), .csr_we_o(csr_we_o),
        .is_ecall_o(is_ecall_o), .is_mret_o(is_mret_o),
        .mepc_o(mepc_o), .mcause_o(mcause_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .rd_o(rd_o), .rd_we_o(rd_we_o), .rd_wdata_o(rd_wdata_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Every output at zero (reset / idle view apart from in_ready_o).
    task automatic chk_quiet(input string tag);
        chk({tag, ".addr"},   csr_addr_o, 0);
        chk({tag, ".we"},     csr_we_o, 0);
        chk({tag, ".wdata"},  csr_wdata_o, 0);
        chk({tag, ".ecall"},  is_ecall_o, 0);
        chk({tag, ".mret"},   is_mret_o, 0);
        chk({tag, ".mepc"},   mepc_o, 0);
        chk({tag, ".mcause"}, mcause_o, 0);
        chk({tag, ".ovld"},   out_valid_o, 0);
        chk({tag, ".rd"},     rd_o, 0);
        chk({tag, ".rdwe"},   rd_we_o, 0);
        chk({tag, ".rdwd"},   rd_wdata_o, 0);
        chk({tag, ".redir"},  redirect_o, 0);
        chk({tag, ".rpc"},    redirect_pc_o, 0);
        chk({tag, ".ill"},    illegal_o, 0);
    endtask

    task automatic scramble_inputs();
        op_i       = 3'($urandom);
        is_ecall_i = 1'($urandom);
        is_mret_i  = 1'($urandom);
        csr_addr_i = 12'($urandom);
        rs1_data_i = $urandom;
        zimm_i     = 5'($urandom);
        rd_i       = 5'($urandom);
        pc_i       = $urandom;
    endtask

    // Runs one instruction starting at a falling edge with the DUT idle.
    // Ends at the falling edge after the output handshake (DUT idle again),
    // or after reset release when rst_in_write is set.
    task automatic run_txn(input logic ec, input logic mr, input logic [2:0] op,
                           input logic [11:0] addr, input logic [31:0] rs1,
                           input logic [4:0] zimm, input logic [4:0] rd,
                           input logic [31:0] pc, input logic [31:0] old,
                           input int stall, input bit rst_in_write);
        logic        k_ecall, k_mret, k_csr, k_ill, k_we, e_rdwe;
        logic [31:0] src, nv, e_wdata, e_rpc;
        logic [11:0] e_addr;

        // Reference model of the instruction's effect.
        k_ecall = ec;
        k_mret  = !ec && mr;
        k_csr   = !k_ecall && !k_mret;
        k_ill   = k_csr && (op == 3'b000 || op == 3'b100);
        src     = (op >= 3'b101) ? {27'd0, zimm} : rs1;
        if (op == 3'b001 || op == 3'b101)      nv = src;
        else if (op == 3'b010 || op == 3'b110) nv = old | src;
        else                                   nv = old & ~src;
        k_we    = k_csr && !k_ill && ((op == 3'b001 || op == 3'b101) || zimm != 0);
        e_wdata = k_we ? nv : 32'd0;
        e_addr  = k_ecall ? 12'h305 : (k_mret ? 12'h341 : addr);
        e_rdwe  = k_csr && !k_ill && rd != 0;
        e_rpc   = k_ecall ? (old / 4) * 4 : (k_mret ? old : 32'd0);

        chk("idle.rdy", in_ready_o, 1);
        is_ecall_i = ec; is_mret_i = mr; op_i = op; csr_addr_i = addr;
        rs1_data_i = rs1; zimm_i = zimm; rd_i = rd; pc_i = pc;
        csr_rdata_i = old;
        in_valid_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        scramble_inputs();

        // READ
        chk("rd.rdy", in_ready_o, 0);
        chk("rd.addr", csr_addr_o, e_addr);
        chk("rd.we", csr_we_o | is_ecall_o | is_mret_o, 0);
        chk("rd.ovld", out_valid_o, 0);
        @(negedge clk_i);
        csr_rdata_i = $urandom;

        // WRITE
        chk("wr.we", csr_we_o, k_we);
        chk("wr.wdata", csr_wdata_o, e_wdata);
        chk("wr.ecall", is_ecall_o, k_ecall);
        chk("wr.mret", is_mret_o, k_mret);
        chk("wr.mepc", mepc_o, k_ecall ? pc : 32'd0);
        chk("wr.mcause", mcause_o, k_ecall ? 32'd11 : 32'd0);
        chk("wr.addr", csr_addr_o, e_addr);
        chk("wr.ovld", out_valid_o, 0);

        if (rst_in_write) begin
            rst_i = 1'b0;
            #1;
            chk_quiet("rst_async");
            chk("rst_async.rdy", in_ready_o, 0);
            @(negedge clk_i);
            chk_quiet("rst_hold");
            @(negedge clk_i);
            rst_i = 1'b1;
            @(negedge clk_i);
            chk("rst_rel.rdy", in_ready_o, 1);
            chk_quiet("rst_rel");
            return;
        end
        @(negedge clk_i);

        // RESP, possibly held by backpressure
        for (int i = 0; i <= stall; i++) begin
            chk("rsp.ovld", out_valid_o, 1);
            chk("rsp.rdy", in_ready_o, 0);
            chk("rsp.strobes", {csr_we_o, is_ecall_o, is_mret_o}, 0);
            chk("rsp.addr", csr_addr_o, 0);
            chk("rsp.rd", rd_o, k_csr ? rd : 5'd0);
            chk("rsp.rdwe", rd_we_o, e_rdwe);
            chk("rsp.rdwd", rd_wdata_o, k_csr ? old : 32'd0);
            chk("rsp.redir", redirect_o, !k_csr);
            chk("rsp.rpc", redirect_pc_o, e_rpc);
            chk("rsp.ill", illegal_o, k_ill);
            if (i == stall) out_ready_i = 1'b1;
            @(negedge clk_i);
        end
        out_ready_i = 1'b0;
        chk("post.ovld", out_valid_o, 0);
        chk("post.rdy", in_ready_o, 1);
    endtask

    initial begin
        logic [2:0] rop;
        // Reset held: all outputs low
        #1;
        chk_quiet("reset");
        chk("reset.rdy", in_ready_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("reset_rel.rdy", in_ready_o, 1);
        chk_quiet("reset_rel");

        // CSRRW 0x300, rs1=0xDEADBEEF, old=0x1800, rd=5
        run_txn(0, 0, 3'b001, 12'h300, 32'hDEAD_BEEF, 5'd3, 5'd5, 32'h0, 32'h1800, 0, 0);
        // CSRRS with x0 source and rd=x0: no write, no writeback
        run_txn(0, 0, 3'b010, 12'h341, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0, 32'h8000_0010, 0, 0);
        // CSRRCI zimm=5, old=0xF -> 0xA
        run_txn(0, 0, 3'b111, 12'h344, 32'h0, 5'h5, 5'd7, 32'h0, 32'hF, 0, 0);
        // CSRRWI with rd=x0 still writes
        run_txn(0, 0, 3'b101, 12'h340, 32'h0, 5'h0, 5'd0, 32'h0, 32'h1234, 0, 0);
        // ecall (with is_mret_i also set: ecall wins)
        run_txn(1, 1, 3'b001, 12'h123, 32'h0, 5'd1, 5'd9, 32'h8000_0100, 32'h8000_0003, 0, 0);
        // mret
        run_txn(0, 1, 3'b010, 12'h456, 32'h0, 5'd1, 5'd9, 32'h0, 32'h8000_0104, 0, 0);
        // Backpressure for 5 cycles, then back-to-back instruction
        run_txn(0, 0, 3'b011, 12'h300, 32'h0000_00F0, 5'd4, 5'd12, 32'h0, 32'hFFFF_FFFF, 5, 0);
        run_txn(0, 0, 3'b110, 12'h305, 32'h0, 5'h1F, 5'd1, 32'h0, 32'h100, 0, 0);
        // Illegal op 100
        run_txn(0, 0, 3'b100, 12'h300, 32'h5555_5555, 5'd3, 5'd4, 32'h0, 32'h77, 0, 0);
        // Reset asserted in WRITE of an ecall
        run_txn(1, 0, 3'b000, 12'h0, 32'h0, 5'd0, 5'd0, 32'h8000_0200, 32'h8000_0000, 0, 1);
        run_txn(0, 0, 3'b001, 12'h300, 32'hCAFE_F00D, 5'd2, 5'd3, 32'h0, 32'h1, 0, 0);

        // Randomized instructions
        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom);
            run_txn(($urandom % 6) == 0, ($urandom % 5) == 0, rop, 12'($urandom), $urandom,
                    ($urandom % 3 == 0) ? 5'd0 : 5'($urandom),
                    ($urandom % 4 == 0) ? 5'd0 : 5'($urandom),
                    $urandom, $urandom, int'($urandom % 4), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
